// File: rtl/o_col_drain_arb.sv
// o_col_drain_arb: quantises the per-column accumulator outputs of a systolic
// array, queues each column in its own FIFO, and drains the FIFOs
// round-robin into a single valid/ready output stream.
module o_col_drain_arb #(
    parameter int COL    = 3,
    parameter int W_ACC  = 32,
    parameter int W_DATA = 8,
    parameter int W_ADDR = 4,
    parameter int W_CH   = $clog2(COL)
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [COL*W_ACC-1:0]   i_acc_data,
    input  logic [COL-1:0]         i_acc_valid,
    input  logic                   i_relu_en,
    input  logic [4:0]             i_shift,
    output logic [W_DATA-1:0]      o_data,
    output logic [W_CH-1:0]        o_chan,
    output logic                   o_last,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [COL-1:0]         o_fifo_empty,
    output logic [COL-1:0]         o_fifo_full,
    output logic [COL-1:0]         o_overflow
);

    localparam int DEPTH = 2 ** W_ADDR;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // Arithmetic shift followed by clipping to the unsigned (ReLU) or signed
    // output range; the result is the low W_DATA bits of the clipped value.
    function automatic logic [W_DATA-1:0] quantise(
        input logic signed [W_ACC-1:0] x,
        input logic                    relu,
        input logic [4:0]              sh
    );
        logic signed [W_ACC-1:0] y;
        logic signed [W_ACC-1:0] umax;
        logic signed [W_ACC-1:0] smax;
        logic signed [W_ACC-1:0] smin;
        logic [W_DATA-1:0]       res;
        umax = {{(W_ACC-W_DATA){1'b0}}, {W_DATA{1'b1}}};
        smax = {{(W_ACC-W_DATA+1){1'b0}}, {(W_DATA-1){1'b1}}};
        smin = {{(W_ACC-W_DATA+1){1'b1}}, {(W_DATA-1){1'b0}}};
        y    = x >>> sh;
        if (relu) begin
            if (x < $signed({W_ACC{1'b0}})) begin
                res = {W_DATA{1'b0}};
            end else if (y > umax) begin
                res = {W_DATA{1'b1}};
            end else begin
                res = y[W_DATA-1:0];
            end
        end else begin
            if (y > smax) begin
                res = smax[W_DATA-1:0];
            end else if (y < smin) begin
                res = smin[W_DATA-1:0];
            end else begin
                res = y[W_DATA-1:0];
            end
        end
        return res;
    endfunction

    // Quantise stage registers
    logic [W_DATA-1:0] q_data_q   [COL];
    logic [W_DATA-1:0] q_data_d   [COL];
    logic [COL-1:0]    q_valid_q, q_valid_d;

    // FIFO storage and pointers (extra MSB is the wrap bit)
    logic [W_DATA-1:0] mem_q      [COL][DEPTH];
    logic [W_ADDR:0]   wr_ptr_q   [COL];
    logic [W_ADDR:0]   wr_ptr_d   [COL];
    logic [W_ADDR:0]   rd_ptr_q   [COL];
    logic [W_ADDR:0]   rd_ptr_d   [COL];
    logic [COL-1:0]    overflow_q, overflow_d;

    // Output register, FSM and arbiter state
    state_t            state_q, state_d;
    logic [W_DATA-1:0] data_q, data_d;
    logic [W_CH-1:0]   chan_q, chan_d;
    logic              last_q, last_d;
    logic [W_CH-1:0]   last_grant_q, last_grant_d;

    // Combinational helpers
    logic [COL-1:0]    fifo_empty_s, fifo_full_s, wr_en_s, pop_s;
    logic [W_CH-1:0]   grant_s;
    logic              any_ne_s;
    logic              load_s;

    // Quantise every channel using the mode/shift presented with its data
    always_comb begin
        q_valid_d = i_acc_valid;
        for (int c = 0; c < COL; c++) begin
            q_data_d[c] = quantise(i_acc_data[c*W_ACC +: W_ACC], i_relu_en, i_shift);
        end
    end

    // FIFO status, write enables (full FIFOs drop writes) and sticky overflow
    always_comb begin
        overflow_d = overflow_q;
        for (int c = 0; c < COL; c++) begin
            fifo_empty_s[c] = (wr_ptr_q[c] == rd_ptr_q[c]);
            fifo_full_s[c]  = (wr_ptr_q[c][W_ADDR-1:0] == rd_ptr_q[c][W_ADDR-1:0]) &&
                              (wr_ptr_q[c][W_ADDR] != rd_ptr_q[c][W_ADDR]);
            wr_en_s[c]      = q_valid_q[c] && !fifo_full_s[c];
            overflow_d[c]   = overflow_q[c] | (q_valid_q[c] & fifo_full_s[c]);
        end
    end

    // Round-robin search over non-empty FIFOs starting after the last grant
    always_comb begin
        logic [W_CH-1:0] cand;
        logic            hit;
        grant_s  = {W_CH{1'b0}};
        any_ne_s = 1'b0;
        for (int i = 0; i < COL; i++) begin
            cand     = W_CH'((int'(last_grant_q) + 1 + i) % COL);
            hit      = !any_ne_s && !fifo_empty_s[cand];
            grant_s  = hit ? cand : grant_s;
            any_ne_s = any_ne_s | hit;
        end
    end

    // Output FSM: load the output register whenever it is free or being accepted
    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        chan_d       = chan_q;
        last_d       = last_q;
        last_grant_d = last_grant_q;
        pop_s        = {COL{1'b0}};
        case (state_q)
            ST_EMPTY: load_s = any_ne_s;
            ST_FULL:  load_s = i_ready && any_ne_s;
            default:  load_s = 1'b0;
        endcase
        if (load_s) begin
            pop_s[grant_s] = 1'b1;
            data_d         = mem_q[grant_s][rd_ptr_q[grant_s][W_ADDR-1:0]];
            chan_d         = grant_s;
            last_d         = (grant_s == W_CH'(COL-1));
            last_grant_d   = grant_s;
            state_d        = ST_FULL;
        end else if ((state_q == ST_FULL) && i_ready) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end
    end

    // Pointer advance; a push and a pop on the same FIFO both take effect
    always_comb begin
        for (int c = 0; c < COL; c++) begin
            wr_ptr_d[c] = wr_ptr_q[c] + (W_ADDR+1)'(wr_en_s[c]);
            rd_ptr_d[c] = rd_ptr_q[c] + (W_ADDR+1)'(pop_s[c]);
        end
    end

    // State registers with synchronous reset that discards all queued data
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_valid_q    <= {COL{1'b0}};
            overflow_q   <= {COL{1'b0}};
            state_q      <= ST_EMPTY;
            data_q       <= {W_DATA{1'b0}};
            chan_q       <= {W_CH{1'b0}};
            last_q       <= 1'b0;
            last_grant_q <= W_CH'(COL-1);
            for (int c = 0; c < COL; c++) begin
                q_data_q[c] <= {W_DATA{1'b0}};
                wr_ptr_q[c] <= {(W_ADDR+1){1'b0}};
                rd_ptr_q[c] <= {(W_ADDR+1){1'b0}};
            end
        end else begin
            q_valid_q    <= q_valid_d;
            overflow_q   <= overflow_d;
            state_q      <= state_d;
            data_q       <= data_d;
            chan_q       <= chan_d;
            last_q       <= last_d;
            last_grant_q <= last_grant_d;
            q_data_q     <= q_data_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    // FIFO storage write; contents need no reset since pointers define validity
    always_ff @(posedge i_clk) begin
        for (int c = 0; c < COL; c++) begin
            if (wr_en_s[c]) begin
                mem_q[c][wr_ptr_q[c][W_ADDR-1:0]] <= q_data_q[c];
            end
        end
    end

    assign o_data       = data_q;
    assign o_chan       = chan_q;
    assign o_last       = last_q;
    assign o_valid      = (state_q == ST_FULL);
    assign o_fifo_empty = fifo_empty_s;
    assign o_fifo_full  = fifo_full_s;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_o_col_drain_arb.sv
// Scoreboard bench for o_col_drain_arb: stimulus pushes hand-computed expected
// samples into per-channel queues, a monitor pops and compares on each transfer.
module tb_o_col_drain_arb;

    localparam int COL = 3;
    localparam int W_ACC = 32;
    localparam int W_DATA = 8;
    localparam int W_ADDR = 4;
    localparam int W_CH = 2;

    logic                 i_clk;
    logic                 i_rst;
    logic [COL*W_ACC-1:0] i_acc_data;
    logic [COL-1:0]       i_acc_valid;
    logic                 i_relu_en;
    logic [4:0]           i_shift;
    logic [W_DATA-1:0]    o_data;
    logic [W_CH-1:0]      o_chan;
    logic                 o_last;
    logic                 o_valid;
    logic                 i_ready;
    logic [COL-1:0]       o_fifo_empty;
    logic [COL-1:0]       o_fifo_full;
    logic [COL-1:0]       o_overflow;

    o_col_drain_arb #(
        .COL(COL), .W_ACC(W_ACC), .W_DATA(W_DATA), .W_ADDR(W_ADDR), .W_CH(W_CH)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_acc_data(i_acc_data), .i_acc_valid(i_acc_valid),
        .i_relu_en(i_relu_en), .i_shift(i_shift), .o_data(o_data), .o_chan(o_chan),
        .o_last(o_last), .o_valid(o_valid), .i_ready(i_ready), .o_fifo_empty(o_fifo_empty),
        .o_fifo_full(o_fifo_full), .o_overflow(o_overflow)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    logic [7:0] sb0[$], sb1[$], sb2[$];
    int chan_log[$];
    int stamp_log[$];
    int n_xfer = 0;
    int n_chk = 0;
    int n_pass = 0;
    bit full0_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: every accepted sample is compared with the head of its channel queue
    always @(negedge i_clk) begin
        if (o_fifo_full[0]) full0_seen = 1'b1;
        if (!i_rst && o_valid && i_ready) begin
            chan_log.push_back(int'(o_chan));
            stamp_log.push_back(cyc);
            n_xfer++;
            chk("last_flag", o_last, (o_chan == 2'd2));
            case (o_chan)
                2'd0: begin
                    chk("ch0_expected", sb0.size() > 0, 1);
                    if (sb0.size() > 0) chk("ch0_data", o_data, sb0.pop_front());
                end
                2'd1: begin
                    chk("ch1_expected", sb1.size() > 0, 1);
                    if (sb1.size() > 0) chk("ch1_data", o_data, sb1.pop_front());
                end
                2'd2: begin
                    chk("ch2_expected", sb2.size() > 0, 1);
                    if (sb2.size() > 0) chk("ch2_data", o_data, sb2.pop_front());
                end
                default: chk("bad_chan", o_chan, 0);
            endcase
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic [2:0] v, input int d0, input int d1, input int d2,
                        input logic relu, input logic [4:0] sh, output int t);
        i_acc_valid = v;
        i_acc_data  = {32'(d2), 32'(d1), 32'(d0)};
        i_relu_en   = relu;
        i_shift     = sh;
        @(posedge i_clk);
        #1;
        t = cyc;
        i_acc_valid = 3'b000;
    endtask

    task automatic wait_drain(input int max);
        int k = 0;
        while (((sb0.size() + sb1.size() + sb2.size()) > 0 || o_valid) && k < max) begin
            tick();
            k++;
        end
        chk("drain_in_time", k < max, 1);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int t0, t1, tdum;
    int rr_exp[6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        i_rst = 1'b1; i_acc_valid = 3'b000; i_acc_data = '0;
        i_relu_en = 1'b0; i_shift = 5'd0; i_ready = 1'b0;
        tick(); tick();
        // Reset state
        chk("rst_valid", o_valid, 0);
        chk("rst_data", o_data, 0);
        chk("rst_chan", o_chan, 0);
        chk("rst_last", o_last, 0);
        chk("rst_empty", o_fifo_empty, 3'b111);
        chk("rst_full", o_fifo_full, 3'b000);
        chk("rst_ovf", o_overflow, 3'b000);
        i_rst = 1'b0;

        // ReLU quantise: 1000>>2=250, -5 -> 0, 300>>2=75; latency t+2
        i_ready = 1'b1;
        chan_log.delete();
        sb0.push_back(8'd250); sb1.push_back(8'd0); sb2.push_back(8'd75);
        push(3'b111, 1000, -5, 300, 1'b1, 5'd2, t0);
        tick();
        chk("lat_t1_valid", o_valid, 0);
        chk("lat_t1_empty", o_fifo_empty, 3'b000);
        tick();
        chk("lat_t2_valid", o_valid, 1);
        chk("lat_t2_chan", o_chan, 0);
        wait_drain(20);
        chk("relu_order0", chan_log.size() > 0 ? chan_log[0] : -1, 0);
        chk("relu_order2", chan_log.size() > 2 ? chan_log[2] : -1, 2);

        // Saturation: 4096 -> 255 (ReLU); -300 -> 0x80, 200 -> 0x7F (signed)
        sb0.push_back(8'd255);
        push(3'b001, 4096, 0, 0, 1'b1, 5'd0, tdum);
        sb0.push_back(8'h80); sb1.push_back(8'h7F);
        push(3'b011, -300, 200, 0, 1'b0, 5'd0, tdum);
        wait_drain(20);

        // Round-robin burst after reset: 0,1,2,0,1,2 back to back from t+2
        do_reset();
        chan_log.delete(); stamp_log.delete();
        sb0.push_back(8'd10); sb1.push_back(8'd20); sb2.push_back(8'd30);
        sb0.push_back(8'd11); sb1.push_back(8'd21); sb2.push_back(8'd31);
        push(3'b111, 10, 20, 30, 1'b1, 5'd0, t0);
        push(3'b111, 11, 21, 31, 1'b1, 5'd0, t1);
        wait_drain(30);
        chk("rr_count", chan_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("rr_chan", i < chan_log.size() ? chan_log[i] : -1, rr_exp[i]);
            chk("rr_cycle", i < stamp_log.size() ? stamp_log[i] : -1, t0 + 2 + i);
        end

        // Backpressure: 18 pushes to ch1; 1 in output reg, 16 in FIFO, last dropped
        i_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i < 17) sb1.push_back(8'(100 + i));
            push(3'b010, 0, 100 + i, 0, 1'b1, 5'd0, tdum);
        end
        tick(); tick();
        chk("bp_full", o_fifo_full, 3'b010);
        chk("bp_ovf", o_overflow, 3'b010);
        chk("bp_valid", o_valid, 1);
        chk("bp_hold_data", o_data, 8'd100);
        tick(); tick(); tick();
        chk("bp_hold_data2", o_data, 8'd100);
        chk("bp_hold_chan", o_chan, 1);
        n_xfer = 0;
        i_ready = 1'b1;
        wait_drain(60);
        chk("bp_drained", n_xfer, 17);
        chk("bp_ovf_sticky", o_overflow, 3'b010);
        chk("bp_empty", o_fifo_empty, 3'b111);

        // Wrap with simultaneous push/pop: 40 samples on ch0, shift 2
        do_reset();
        chk("ovf_cleared", o_overflow, 3'b000);
        full0_seen = 1'b0;
        n_xfer = 0;
        for (int i = 0; i < 40; i++) begin
            sb0.push_back(8'(i));
            push(3'b001, i * 4, 0, 0, 1'b1, 5'd2, tdum);
        end
        wait_drain(40);
        chk("wrap_count", n_xfer, 40);
        chk("wrap_no_full", full0_seen, 0);
        chk("wrap_no_ovf", o_overflow, 3'b000);

        // Reset mid-stream discards queued data; inputs ignored during reset
        i_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(3'b100, 0, 0, i + 1, 1'b1, 5'd0, tdum);
        tick(); tick();
        chk("mid_valid", o_valid, 1);
        i_rst = 1'b1; i_ready = 1'b1; i_acc_valid = 3'b111;
        i_acc_data = {32'd9, 32'd8, 32'd7};
        tick();
        i_rst = 1'b0; i_acc_valid = 3'b000;
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_empty", o_fifo_empty, 3'b111);
        for (int i = 0; i < 5; i++) tick();
        chk("mid_rst_quiet", o_valid, 0);
        chan_log.delete();
        sb0.push_back(8'd1); sb1.push_back(8'd2); sb2.push_back(8'd3);
        push(3'b111, 1, 2, 3, 1'b1, 5'd0, tdum);
        wait_drain(20);
        chk("post_rst_first", chan_log.size() > 0 ? chan_log[0] : -1, 0);
        chk("final_empty", o_fifo_empty, 3'b111);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
